rec_lock_ctrl: RTL and testbench
================================

# rec_lock_ctrl

Acquisition and lock controller for the bit-clock recovery datapath. It sequences the interval estimator: clear, acquire, declare lock, detect loss of signal and re-acquire. It also turns the debounced front-panel keys into a phase-flip pulse and a divider-type select. It runs in the 300 MHz recovery domain, between the key debouncers and the interval estimator / clock-out divider.

## Interface
Parameters:
- CLK_LEN, 16, width of period estimate and locked period
- LOCK_EDGES, 15, consecutive edges without estimate update required to declare lock (1..255)
- LOS_CYCLES, 300000, clock cycles without an edge before loss of signal (2..2^24-1)

Ports:
- clk  in  1  recovery clock, 300 MHz global
- rst  in  1  synchronous, active-high reset
- edge_pulse  in  1  one-cycle pulse per input-signal edge, from estimator
- period_upd  in  1  one-cycle pulse when estimator lowered its minimum interval
- period_est  in  CLK_LEN  current minimum-interval estimate
- cmd_rev  in  1  debounced phase-reverse key, active low
- cmd_type  in  1  debounced type key, active low
- cmd_reacq  in  1  one-cycle forced re-acquire request
- est_clear  out  1  one-cycle pulse: estimator resets its minimum to all-ones
- phase_flip  out  1  one-cycle pulse: clock-out divider inverts clk_rec
- type_sel  out  1  0 = half-period toggle, 1 = full-period toggle
- locked  out  1  high while in LOCKED
- los  out  1  sticky loss-of-signal flag
- period_lock  out  CLK_LEN  estimate latched at lock entry
- state  out  2  IDLE=0, CLEAR=1, ACQUIRE=2, LOCKED=3

## Operation
- Reset values: state IDLE, est_clear 0, phase_flip 0, type_sel 0, locked 0, los 0, period_lock all-ones. Internal key history regs reset to 1; stable_cnt and idle_cnt reset to 0.
- IDLE: unconditionally go to CLEAR next cycle.
- CLEAR: lasts exactly one cycle. est_clear = 1. stable_cnt = 0, idle_cnt = 0. Go to ACQUIRE.
- ACQUIRE:
  - period_upd: stable_cnt = 0.
  - edge_pulse without period_upd: stable_cnt increments, saturating at 255.
  - Lock: when stable_cnt reaches LOCK_EDGES and period_est is not all-ones, go to LOCKED. period_lock = period_est sampled that cycle; los is cleared.
- LOCKED:
  - period_upd: drop to ACQUIRE with stable_cnt = 0. period_lock holds its value.
  - edge_pulse alone: no state change.
- idle_cnt (ACQUIRE and LOCKED only):
  - Cleared on edge_pulse; otherwise increments, saturating.
  - When it reaches LOS_CYCLES-1 without an edge: set los = 1 and go to CLEAR.
- cmd_reacq: from any state except IDLE, go to CLEAR. It has priority over every other transition. It clears los.
- Priority in the same cycle: rst > cmd_reacq > LOS timeout > period_upd > edge_pulse/lock.
- Keys: each key is registered every cycle. A 1->0 transition on cmd_rev gives phase_flip = 1 for one cycle, in any state. A 1->0 transition on cmd_type toggles type_sel, in any state, with no relock. Key levels held low generate nothing further.
- All outputs are registered. locked is a decode of the registered state.

## Timing
- rst deasserted at cycle 0: state = CLEAR and est_clear = 1 at cycle 1; ACQUIRE at cycle 2.
- Lock latency: locked rises one cycle after the edge_pulse that makes stable_cnt = LOCK_EDGES.
- Loss of signal: LOCKED -> CLEAR and los = 1 in the same registered update, LOS_CYCLES cycles after the last edge_pulse. ACQUIRE follows one cycle later.
- phase_flip and type_sel change one cycle after the sampled key falling edge.
- rst asserted mid-operation: all outputs return to reset values the next cycle, including an in-progress est_clear or phase_flip pulse.

## Test plan
- Reset then 15 edge_pulses, no period_upd, period_est = 100 -> est_clear pulse at cycle 1; locked = 1 one cycle after 15th edge; period_lock = 100; state = 3.
- ACQUIRE: 10 edges, period_upd on 11th (period_est 80), then 15 more edges -> lock only after the 15 post-update edges; period_lock = 80.
- LOCKED, LOS_CYCLES = 1000, no edges for 1000 cycles -> los = 1; state = CLEAR then ACQUIRE; est_clear pulse. A subsequent relock clears los.
- cmd_reacq in the same cycle as period_upd and edge_pulse while LOCKED -> state = CLEAR next cycle; los = 0.
- cmd_rev held low 50 cycles, then high, then low again -> exactly two one-cycle phase_flip pulses. Two cmd_type presses -> type_sel 0 -> 1 -> 0; locked unaffected.
- rst asserted one cycle into CLEAR -> est_clear low next cycle; state = IDLE; period_lock = 0xFFFF.

Source files
------------

// File: rtl/rec_lock_ctrl.sv
// rec_lock_ctrl
// Acquisition and lock controller for the bit-clock recovery datapath.
// Sequences the interval estimator (clear, acquire, lock, loss-of-signal,
// re-acquire) and converts the debounced front-panel keys into a
// phase-flip pulse and a divider-type select.
//
// Handshake note: this block has no valid/ready channels. Every input is
// a level or a one-cycle pulse sampled on each rising clk edge, and every
// output is updated on that same edge.
//
// Ports:
//   clk          recovery clock
//   rst          synchronous, active-high reset
//   edge_pulse   one-cycle pulse per input-signal edge
//   period_upd   one-cycle pulse when the estimator lowered its minimum
//   period_est   current minimum-interval estimate
//   cmd_rev      debounced phase-reverse key, active low
//   cmd_type     debounced type key, active low
//   cmd_reacq    one-cycle forced re-acquire request
//   est_clear    one-cycle pulse: estimator resets its minimum
//   phase_flip   one-cycle pulse: clock-out divider inverts clk_rec
//   type_sel     0 = half-period toggle, 1 = full-period toggle
//   locked       high while in LOCKED
//   los          sticky loss-of-signal flag
//   period_lock  estimate latched at lock entry
//   state        IDLE=0, CLEAR=1, ACQUIRE=2, LOCKED=3 (also the FSM debug view)
module rec_lock_ctrl #(
    parameter int CLK_LEN    = 16,
    parameter int LOCK_EDGES = 15,
    parameter int LOS_CYCLES = 300000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               edge_pulse,
    input  logic               period_upd,
    input  logic [CLK_LEN-1:0] period_est,
    input  logic               cmd_rev,
    input  logic               cmd_type,
    input  logic               cmd_reacq,
    output logic               est_clear,
    output logic               phase_flip,
    output logic               type_sel,
    output logic               locked,
    output logic               los,
    output logic [CLK_LEN-1:0] period_lock,
    output logic [1:0]         state
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CLEAR   = 2'd1;
    localparam logic [1:0] S_ACQUIRE = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    localparam logic [7:0]  LOCK_TH  = 8'(LOCK_EDGES);
    localparam logic [23:0] LOS_LAST = 24'(LOS_CYCLES - 1);

    logic [1:0]         r_state;
    logic [7:0]         r_stable_cnt;
    logic [23:0]        r_idle_cnt;
    logic               r_los;
    logic [CLK_LEN-1:0] r_period_lock;
    logic               r_est_clear;
    logic               r_phase_flip;
    logic               r_type_sel;
    logic               r_rev_q;
    logic               r_type_q;

    logic [1:0]         w_next_state;
    logic [7:0]         w_stable_next;
    logic [23:0]        w_idle_next;
    logic               w_los_next;
    logic [CLK_LEN-1:0] w_plock_next;
    logic               w_timeout;
    logic               w_est_valid;
    logic               w_rev_fall;
    logic               w_type_fall;

    // Timeout only fires in a cycle without an edge, so an edge arriving
    // exactly at the limit still keeps the link alive.
    assign w_timeout   = !edge_pulse && (r_idle_cnt >= LOS_LAST);
    assign w_est_valid = (period_est != {CLK_LEN{1'b1}});
    assign w_rev_fall  = r_rev_q & ~cmd_rev;
    assign w_type_fall = r_type_q & ~cmd_type;

    always_comb begin
        w_next_state  = r_state;
        w_stable_next = r_stable_cnt;
        w_idle_next   = r_idle_cnt;
        w_los_next    = r_los;
        w_plock_next  = r_period_lock;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_CLEAR;
            end
            S_CLEAR: begin
                w_stable_next = 8'd0;
                w_idle_next   = 24'd0;
                if (cmd_reacq) begin
                    w_next_state = S_CLEAR;
                    w_los_next   = 1'b0;
                end else begin
                    w_next_state = S_ACQUIRE;
                end
            end
            default: begin // S_ACQUIRE, S_LOCKED
                if (cmd_reacq) begin
                    w_next_state = S_CLEAR;
                    w_los_next   = 1'b0;
                end else if (w_timeout) begin
                    w_next_state = S_CLEAR;
                    w_los_next   = 1'b1;
                end else begin
                    if (edge_pulse) begin
                        w_idle_next = 24'd0;
                    end else if (r_idle_cnt != 24'hFF_FFFF) begin
                        w_idle_next = r_idle_cnt + 24'd1;
                    end
                    if (period_upd) begin
                        w_stable_next = 8'd0;
                        w_next_state  = S_ACQUIRE;
                    end else if (edge_pulse && r_stable_cnt != 8'hFF) begin
                        w_stable_next = r_stable_cnt + 8'd1;
                    end
                    // Threshold compare (not equality) so a lock held off by an
                    // all-ones estimate is taken as soon as the estimate is valid.
                    if (r_state == S_ACQUIRE && w_stable_next >= LOCK_TH && w_est_valid) begin
                        w_next_state = S_LOCKED;
                        w_plock_next = period_est;
                        w_los_next   = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_stable_cnt  <= 8'd0;
            r_idle_cnt    <= 24'd0;
            r_los         <= 1'b0;
            r_period_lock <= {CLK_LEN{1'b1}};
            r_est_clear   <= 1'b0;
            r_phase_flip  <= 1'b0;
            r_type_sel    <= 1'b0;
            r_rev_q       <= 1'b1;
            r_type_q      <= 1'b1;
        end else begin
            r_state       <= w_next_state;
            r_stable_cnt  <= w_stable_next;
            r_idle_cnt    <= w_idle_next;
            r_los         <= w_los_next;
            r_period_lock <= w_plock_next;
            // est_clear is high for exactly the cycle spent in CLEAR.
            r_est_clear   <= (w_next_state == S_CLEAR);
            r_phase_flip  <= w_rev_fall;
            if (w_type_fall) begin
                r_type_sel <= ~r_type_sel;
            end
            r_rev_q       <= cmd_rev;
            r_type_q      <= cmd_type;
        end
    end

    assign est_clear   = r_est_clear;
    assign phase_flip  = r_phase_flip;
    assign type_sel    = r_type_sel;
    assign locked      = (r_state == S_LOCKED);
    assign los         = r_los;
    assign period_lock = r_period_lock;
    assign state       = r_state;

endmodule

// File: tb/tb_rec_lock_ctrl.sv
module tb_rec_lock_ctrl;
  localparam int CLK_LEN    = 16;
  localparam int LOCK_EDGES = 15;
  localparam int LOS_CYCLES = 1000;
  localparam int OW         = 5 + CLK_LEN + 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic edge_pulse, period_upd, cmd_rev, cmd_type, cmd_reacq;
  logic [CLK_LEN-1:0] period_est;
  logic est_clear, phase_flip, type_sel, locked, los;
  logic [CLK_LEN-1:0] period_lock;
  logic [1:0] state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rec_lock_ctrl #(
    .CLK_LEN(CLK_LEN), .LOCK_EDGES(LOCK_EDGES), .LOS_CYCLES(LOS_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .edge_pulse(edge_pulse), .period_upd(period_upd),
    .period_est(period_est), .cmd_rev(cmd_rev), .cmd_type(cmd_type),
    .cmd_reacq(cmd_reacq), .est_clear(est_clear), .phase_flip(phase_flip),
    .type_sel(type_sel), .locked(locked), .los(los),
    .period_lock(period_lock), .state(state)
  );

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  string tag = "reset";

  // ---------------- reference model ----------------
  // Model phases: 0 idle, 1 clearing, 2 acquiring, 3 locked.
  int m_phase, m_edges, m_quiet;
  bit m_clear, m_flip, m_type, m_los, m_rev_prev, m_type_prev;
  logic [CLK_LEN-1:0] m_plock;

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_edges = 0; m_quiet = 0;
      m_clear = 0; m_flip = 0; m_type = 0; m_los = 0;
      m_rev_prev = 1; m_type_prev = 1;
      m_plock = '1;
    end else begin
      m_flip = m_rev_prev && !cmd_rev;
      if (m_type_prev && !cmd_type) m_type = !m_type;
      m_rev_prev = cmd_rev;
      m_type_prev = cmd_type;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_edges = 0;
        m_quiet = 0;
        if (cmd_reacq) m_los = 0;
        else m_phase = 2;
      end else if (cmd_reacq) begin
        m_phase = 1;
        m_los = 0;
      end else if (!edge_pulse && m_quiet >= LOS_CYCLES - 1) begin
        m_phase = 1;
        m_los = 1;
      end else begin
        m_quiet = edge_pulse ? 0 : m_quiet + 1;
        if (period_upd) begin
          m_edges = 0;
          m_phase = 2;
        end else if (edge_pulse) begin
          m_edges = (m_edges >= 255) ? 255 : m_edges + 1;
        end
        if (m_phase == 2 && m_edges >= LOCK_EDGES && period_est != '1) begin
          m_phase = 3;
          m_plock = period_est;
          m_los = 0;
        end
      end
      m_clear = (m_phase == 1);
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    return {m_clear, m_flip, m_type, (m_phase == 3), m_los, m_plock, 2'(m_phase)};
  endfunction

  // ---------------- driver ----------------
  logic n_rst, n_rev, n_type;
  logic [CLK_LEN-1:0] n_est;

  task automatic tick(input logic e, input logic u, input logic q);
    @(negedge clk);
    rst        = n_rst;
    period_est = n_est;
    cmd_rev    = n_rev;
    cmd_type   = n_type;
    edge_pulse = e;
    period_upd = u;
    cmd_reacq  = q;
    model_step();
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [OW-1:0] act, exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        act = {est_clear, phase_flip, type_sel, locked, los, period_lock, state};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL cyc=%0d outputs[%s]: got clr=%0b flip=%0b type=%0b lock=%0b los=%0b plock=%h st=%0d, want clr=%0b flip=%0b type=%0b lock=%0b los=%0b plock=%h st=%0d",
                   cyc, tag, act[OW-1], act[OW-2], act[OW-3], act[OW-4], act[OW-5],
                   act[CLK_LEN+1:2], act[1:0], exp[OW-1], exp[OW-2], exp[OW-3],
                   exp[OW-4], exp[OW-5], exp[CLK_LEN+1:2], exp[1:0]);
        end
      end
    end
  end

  // Watchdog: the stimulus is finite, this only guards against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; edge_pulse = 1'b0; period_upd = 1'b0; cmd_reacq = 1'b0;
    cmd_rev = 1'b1; cmd_type = 1'b1; period_est = 16'd100;
    n_rst = 1'b1; n_rev = 1'b1; n_type = 1'b1; n_est = 16'd100;

    tag = "reset";
    idle(3);
    n_rst = 1'b0;

    tag = "first_lock";
    idle(2);
    edges(15);
    idle(3);

    tag = "upd_drop_relock";
    n_est = 16'd90;
    tick(1'b0, 1'b1, 1'b0);
    edges(10);
    n_est = 16'd80;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    edges(15);
    idle(2);

    tag = "los";
    idle(LOS_CYCLES + 5);
    tag = "relock_after_los";
    edges(15);
    idle(2);

    tag = "reacq_priority";
    tick(1'b1, 1'b1, 1'b1);
    idle(3);
    edges(15);

    tag = "est_all_ones";
    tick(1'b0, 1'b1, 1'b0);
    n_est = '1;
    edges(20);
    n_est = 16'd50;
    idle(3);

    tag = "keys";
    n_rev = 1'b0; idle(50);
    n_rev = 1'b1; idle(4);
    n_rev = 1'b0; idle(5);
    n_rev = 1'b1; idle(2);
    n_type = 1'b0; idle(3);
    n_type = 1'b1; idle(3);
    n_type = 1'b0; idle(3);
    n_type = 1'b1; idle(3);

    tag = "rst_in_clear";
    tick(1'b0, 1'b0, 1'b1);
    n_rst = 1'b1; idle(1);
    n_rst = 1'b0; idle(3);

    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) n_rev = ~n_rev;
      if ($urandom_range(0, 19) == 0) n_type = ~n_type;
      if ($urandom_range(0, 99) == 0)
        n_est = ($urandom_range(0, 7) == 0) ? '1 : 16'($urandom_range(20, 200));
      n_rst = ($urandom_range(0, 799) == 0);
      tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 79) == 0),
           ($urandom_range(0, 299) == 0));
    end
    n_rst = 1'b0;
    idle(3);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
